// File: rtl/mac_array_ctrl.sv
// Sequencing controller for a ROWS x COLS systolic MAC array: weight load,
// skewed compute enables and result flagging, one pass per accepted start.

module mac_row_en #(
  parameter int CW = 9
) (
  input  logic [CW-1:0] t,
  input  logic [CW-1:0] lo,
  input  logic [CW-1:0] hi,
  output logic          dis
);
  assign dis = !((t >= lo) && (t <= hi));
endmodule

module mac_array_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int AW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   num_vec,
  output logic            busy,
  output logic            done,
  output logic [COLS-1:0] wen,
  output logic [ROWS-1:0] en_row,
  output logic [COLS-1:0] en_self,
  output logic            w_rd_en,
  output logic [AW-1:0]   w_rd_addr,
  output logic            a_rd_en,
  output logic [AW-1:0]   a_rd_addr,
  output logic            res_valid,
  output logic [AW-1:0]   res_idx
);
  // Wide enough that num_vec + ROWS + COLS - 1 never wraps.
  localparam int CW = $clog2((1 << AW) + ROWS + COLS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD_W  = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [CW-1:0] ROWS_M1 = CW'(ROWS - 1);
  localparam logic [CW-1:0] RC1    = CW'(ROWS + COLS - 1);

  logic [1:0]    st, nst;
  logic [CW-1:0] cnt, ncnt;
  logic [AW-1:0] nv, nnv;
  logic [CW-1:0] len, nnv_x, waddr_w, ridx_w;

  logic            busy_d, done_d, w_rd_en_d, a_rd_en_d, res_valid_d;
  logic [COLS-1:0] wen_d, en_self_d;
  logic [ROWS-1:0] en_row_d, row_dis;
  logic [AW-1:0]   w_rd_addr_d, a_rd_addr_d, res_idx_d;

  assign len     = CW'(nv) + RC1;
  assign nnv_x   = CW'(nnv);
  assign waddr_w = ROWS_M1 - ncnt;
  assign ridx_w  = ncnt - RC1;

  always_comb begin
    nst  = st;
    ncnt = cnt;
    nnv  = nv;
    case (st)
      S_IDLE: if (start) begin
        nst  = S_LOAD_W;
        ncnt = '0;
        nnv  = num_vec;
      end
      S_LOAD_W: begin
        if (cnt == ROWS_C) begin
          ncnt = '0;
          nst  = (nv != '0) ? S_COMPUTE : S_DONE;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cnt == len - 1'b1) begin
          ncnt = '0;
          nst  = S_DONE;
        end else begin
          ncnt = cnt + 1'b1;
        end
      end
      default: begin
        nst  = S_IDLE;
        ncnt = '0;
      end
    endcase
    if (abort && (st != S_IDLE)) begin
      nst  = S_IDLE;
      ncnt = '0;
    end
  end

  // Row r is live for the num_vec cycles starting one cycle after its upper neighbour.
  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      logic [CW-1:0] lo, hi;
      assign lo = CW'(r + 1);
      assign hi = CW'(r) + nnv_x;
      mac_row_en #(.CW(CW)) u_row (.t(ncnt), .lo(lo), .hi(hi), .dis(row_dis[r]));
    end
  endgenerate

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wen_d       = '0;
    en_row_d    = '1;
    en_self_d   = '1;
    w_rd_en_d   = 1'b0;
    w_rd_addr_d = w_rd_addr;
    a_rd_en_d   = 1'b0;
    a_rd_addr_d = a_rd_addr;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx;
    case (nst)
      S_IDLE: begin
        w_rd_addr_d = '0;
        a_rd_addr_d = '0;
        res_idx_d   = '0;
      end
      S_LOAD_W: begin
        busy_d = 1'b1;
        if (ncnt < ROWS_C) begin
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = waddr_w[AW-1:0];
        end
        if (ncnt != '0) wen_d = '1;
      end
      S_COMPUTE: begin
        busy_d    = 1'b1;
        en_self_d = '0;
        en_row_d  = row_dis;
        if (ncnt < nnv_x) begin
          a_rd_en_d   = 1'b1;
          a_rd_addr_d = ncnt[AW-1:0];
        end
        if (ncnt >= RC1) begin
          res_valid_d = 1'b1;
          res_idx_d   = ridx_w[AW-1:0];
        end
      end
      default: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      cnt       <= '0;
      nv        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wen       <= '0;
      en_row    <= '1;
      en_self   <= '1;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      a_rd_en   <= 1'b0;
      a_rd_addr <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
    end else begin
      st        <= nst;
      cnt       <= ncnt;
      nv        <= nnv;
      busy      <= busy_d;
      done      <= done_d;
      wen       <= wen_d;
      en_row    <= en_row_d;
      en_self   <= en_self_d;
      w_rd_en   <= w_rd_en_d;
      w_rd_addr <= w_rd_addr_d;
      a_rd_en   <= a_rd_en_d;
      a_rd_addr <= a_rd_addr_d;
      res_valid <= res_valid_d;
      res_idx   <= res_idx_d;
    end
  end
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl (4x4, AW=8): cycle table for a full pass
// plus hand sequences for num_vec=0, abort, async reset and back-to-back passes.

module tb_mac_array_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] num_vec;
  logic       busy, done, w_rd_en, a_rd_en, res_valid;
  logic [3:0] wen, en_row, en_self;
  logic [7:0] w_rd_addr, a_rd_addr, res_idx;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_array_ctrl #(.ROWS(4), .COLS(4), .AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vec(num_vec),
    .busy(busy), .done(done), .wen(wen), .en_row(en_row), .en_self(en_self),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en),
    .a_rd_addr(a_rd_addr), .res_valid(res_valid), .res_idx(res_idx)
  );

  typedef struct packed {
    logic       busy, done;
    logic [3:0] wen, en_row, en_self;
    logic       w_rd_en;
    logic [7:0] w_rd_addr;
    logic       a_rd_en;
    logic [7:0] a_rd_addr;
    logic       res_valid;
    logic [7:0] res_idx;
  } out_t;

  typedef struct {
    logic       start, abort;
    logic [7:0] nv;
    out_t       exp;
  } vec_t;

  vec_t tbl[18];

  function automatic out_t mk(logic b, logic d, logic [3:0] w, logic [3:0] er, logic [3:0] es,
                              logic wre, logic [7:0] wa, logic ae, logic [7:0] aa,
                              logic rv, logic [7:0] ri);
    out_t o;
    o = '{busy:b, done:d, wen:w, en_row:er, en_self:es, w_rd_en:wre, w_rd_addr:wa,
          a_rd_en:ae, a_rd_addr:aa, res_valid:rv, res_idx:ri};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{busy:busy, done:done, wen:wen, en_row:en_row, en_self:en_self, w_rd_en:w_rd_en,
          w_rd_addr:w_rd_addr, a_rd_en:a_rd_en, a_rd_addr:a_rd_addr,
          res_valid:res_valid, res_idx:res_idx};
    return o;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = sample();
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  out_t idle_o;

  initial begin
    idle_o = mk(0, 0, 4'h0, 4'hF, 4'hF, 0, 8'd0, 0, 8'd0, 0, 8'd0);
    // One pass, num_vec=3, start in cycle 0.
    tbl[0]  = '{1'b1, 1'b0, 8'd3, idle_o};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hF, 4'hF, 1, 8'd3, 0, 8'd0, 0, 8'd0)};
    tbl[2]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 8'd2, 0, 8'd0, 0, 8'd0)};
    tbl[3]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 8'd1, 0, 8'd0, 0, 8'd0)};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'hF, 4'hF, 4'hF, 1, 8'd0, 0, 8'd0, 0, 8'd0)};
    tbl[5]  = '{1'b1, 1'b0, 8'd9, mk(1, 0, 4'hF, 4'hF, 4'hF, 0, 8'd0, 0, 8'd0, 0, 8'd0)};
    tbl[6]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, 1, 8'd0, 0, 8'd0)};
    tbl[7]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hE, 4'h0, 0, 8'd0, 1, 8'd1, 0, 8'd0)};
    tbl[8]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hC, 4'h0, 0, 8'd0, 1, 8'd2, 0, 8'd0)};
    tbl[9]  = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'h8, 4'h0, 0, 8'd0, 0, 8'd2, 0, 8'd0)};
    tbl[10] = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'h1, 4'h0, 0, 8'd0, 0, 8'd2, 0, 8'd0)};
    tbl[11] = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'h3, 4'h0, 0, 8'd0, 0, 8'd2, 0, 8'd0)};
    tbl[12] = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'h7, 4'h0, 0, 8'd0, 0, 8'd2, 0, 8'd0)};
    tbl[13] = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, 0, 8'd2, 1, 8'd0)};
    tbl[14] = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, 0, 8'd2, 1, 8'd1)};
    tbl[15] = '{1'b0, 1'b0, 8'd0, mk(1, 0, 4'h0, 4'hF, 4'h0, 0, 8'd0, 0, 8'd2, 1, 8'd2)};
    tbl[16] = '{1'b1, 1'b0, 8'd5, mk(1, 1, 4'h0, 4'hF, 4'hF, 0, 8'd0, 0, 8'd2, 0, 8'd2)};
    tbl[17] = '{1'b0, 1'b0, 8'd0, idle_o};

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_vec = 8'd0;
    #12;
    chk("reset", idle_o);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; num_vec = tbl[i].nv;
      chk($sformatf("pass_cyc%0d", i), tbl[i].exp);
      tick();
    end
    start = 1'b0;

    // num_vec=0: straight from LOAD_W to DONE.
    start = 1'b1; num_vec = 8'd0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chkv($sformatf("nv0_cyc%0d", c), {28'd0, busy, done, a_rd_en, res_valid},
           {28'd0, (c <= 6) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0, 1'b0, 1'b0});
      tick();
    end

    // Abort in COMPUTE cycle 9, restart in cycle 10, abort again in LOAD_W.
    start = 1'b1; num_vec = 8'd3;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("abort_pre", mk(1, 0, 4'h0, 4'h8, 4'h0, 0, 8'd0, 0, 8'd2, 0, 8'd0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", idle_o);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_restart", mk(1, 0, 4'h0, 4'hF, 4'hF, 1, 8'd3, 0, 8'd0, 0, 8'd0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load", idle_o);
    tick();
    chk("abort_load_nodone", idle_o);

    // Async reset mid-LOAD_W with start held high.
    start = 1'b1; num_vec = 8'd3;
    tick();
    tick();
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rst_async", idle_o);
    repeat (2) tick();
    chk("rst_hold", idle_o);
    @(negedge clk) begin rst = 1'b0; num_vec = 8'd1; end
    tick();
    chk("rst_release", mk(1, 0, 4'h0, 4'hF, 4'hF, 1, 8'd3, 0, 8'd0, 0, 8'd0));

    // start held high: each LOAD_W begins two cycles after the previous done.
    begin
      int cyc, last_done, passes;
      cyc = 0; last_done = -1; passes = 0;
      while (passes < 2 && cyc < 200) begin
        tick();
        cyc++;
        if (done) last_done = cyc;
        if (busy && w_rd_en && w_rd_addr == 8'd3 && last_done >= 0) begin
          chkv($sformatf("b2b_gap%0d", passes), cyc - last_done, 32'd2);
          last_done = -1;
          passes++;
        end
      end
      if (passes < 2) begin
        n_chk++;
        n_fail++;
        $display("FAIL b2b_timeout: got %0d passes expected 2", passes);
      end
    end
    start = 1'b0;

    begin
      int w;
      w = 0;
      while (busy && w < 100) begin tick(); w++; end
      chk("final_idle", idle_o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequencing controller for the ROWS x COLS systolic MAC array built from the PE blocks.
- Runs one matrix pass per start pulse:
  - Weight-load phase: drives the per-column weight write enable while weights shift south.
  - Compute phase: drives skewed row and column enables and activation-buffer reads.
  - Result phase: flags valid results leaving the array.
- Sits between the host/command interface and the array plus its weight and activation buffers.

Parameters:
ROWS, 4, array rows (2..16)
COLS, 4, array columns (2..16)
AW, 8, address/index width of weight and activation buffers

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE
abort  in  1  synchronous cancel; honoured in any busy state
num_vec  in  AW  activation vectors in this pass; latched on accepted start
busy  out  1  pass in progress (LOAD_W, COMPUTE, DONE)
done  out  1  one-cycle pulse at end of a non-aborted pass
wen  out  COLS  weight write enable, top of each column (drives PE WEN)
en_row  out  ROWS  per-row disable, 1 = PE result cleared (drives PE EN_row)
en_self  out  COLS  per-column disable, 1 = cleared (drives PE EN_self)
w_rd_en  out  1  weight buffer read strobe
w_rd_addr  out  AW  weight buffer address
a_rd_en  out  1  activation buffer read strobe
a_rd_addr  out  AW  activation buffer address
res_valid  out  1  result at east edge valid this cycle
res_idx  out  AW  index of the vector whose result is valid

Behaviour:
- All outputs are registered. Each output value holds for the whole cycle the FSM spends in the corresponding state/count.
- Reset (async, rst=1), and also the IDLE values:
  - busy=0, done=0, wen=0, w_rd_en=0, a_rd_en=0, res_valid=0
  - w_rd_addr=0, a_rd_addr=0, res_idx=0
  - en_row=all 1, en_self=all 1
  - FSM=IDLE, counters=0
- Reset mid-pass aborts immediately. No done pulse.
- FSM states: IDLE -> LOAD_W -> COMPUTE -> DONE -> IDLE.
- IDLE:
  - start=1 latches num_vec and enters LOAD_W next cycle.
  - start is ignored in every other state.
- LOAD_W: ROWS+1 cycles, counter k=0..ROWS.
  - w_rd_en=1 and w_rd_addr=ROWS-1-k for k<ROWS; bottom-row weights are read first.
  - wen=all 1 for k>=1, matching the 1-cycle buffer read latency.
  - en_row and en_self stay all 1.
  - Exit when k=ROWS: to COMPUTE if the latched num_vec>0, else to DONE.
- COMPUTE: L=num_vec+ROWS+COLS-1 cycles, counter t=0..L-1.
  - wen=0 and en_self=all 0.
  - a_rd_en=1 and a_rd_addr=t for t<num_vec; otherwise a_rd_en=0 and a_rd_addr holds its last value.
  - en_row[r]=0 (active) iff r+1 <= t <= r+num_vec; otherwise 1.
  - res_valid=1 iff ROWS+COLS-1 <= t <= L-1. Then res_idx=t-(ROWS+COLS-1); otherwise res_idx holds.
  - After t=L-1, go to DONE.
- DONE: one cycle.
  - done=1, busy=1, all enables at their idle values.
  - Next state is IDLE; a start in DONE is ignored.
- abort=1 in LOAD_W, COMPUTE or DONE:
  - Next cycle is IDLE with idle output values.
  - No done pulse.
  - abort wins over any same-cycle transition.
- Widths:
  - t needs AW+1 bits. L reaches 2^AW-1+ROWS+COLS-1 with no wrap.
  - num_vec=2^AW-1 is legal.
  - Counter wrap is never allowed.
- Back-to-back passes: the earliest next start is accepted in the cycle after DONE (state IDLE).

Test Plan:
- ROWS=COLS=4, num_vec=3, start at cycle 0:
  - LOAD_W occupies cycles 1-5; w_rd_addr=3,2,1,0 in cycles 1-4; wen=4'hF in cycles 2-5.
  - COMPUTE occupies cycles 6-15; a_rd_addr=0,1,2 in cycles 6-8.
  - res_valid in cycles 13-15 with res_idx=0,1,2; done in cycle 16.
- Same pass, checking en_row skew: en_row[0]=0 in cycles 7-9; en_row[3]=0 in cycles 10-12; otherwise 1.
- num_vec=0: LOAD_W in cycles 1-5 then done=1 in cycle 6. a_rd_en and res_valid never assert.
- abort in COMPUTE cycle 9: IDLE and idle outputs from cycle 10, no done. A start in cycle 10 begins a new LOAD_W in cycle 11.
- rst pulse asserted mid-LOAD_W (no clock edge): all outputs take reset values immediately. start is held high throughout; it has no effect until rst deasserts.
- start held high continuously with num_vec=1: passes run back-to-back. Each new LOAD_W begins two cycles after the previous done.
